// File: rtl/block_stats_collector.sv
// Block statistics collector.
// Accepts one score per lane per beat and keeps, for each of the two lanes,
// a running minimum, maximum and saturating sum. It also keeps a count of
// accepted tiles. When the block ends, the statistics are held stable with
// stats_valid asserted until the consumer acknowledges them.
// Scores are unsigned fixed point with FRACTIONAL_BITS fraction bits. Only the
// interpretation of the values depends on that; the arithmetic is plain
// unsigned integer math.

module block_stats_collector #(
    parameter int width           = 8,
    parameter int FRACTIONAL_BITS = 8,
    parameter int MAX_TILES       = 255
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 tile_valid,
    output logic                 tile_ready,
    input  logic                 tile_last,
    input  logic [2*width-1:0]   score0,
    input  logic [2*width-1:0]   score1,
    output logic [2*width-1:0]   noOfTiles,
    output logic [2*width-1:0]   min0,
    output logic [2*width-1:0]   max0,
    output logic [2*width-1:0]   sum0,
    output logic [2*width-1:0]   min1,
    output logic [2*width-1:0]   max1,
    output logic [2*width-1:0]   sum1,
    output logic [1:0]           sum_sat,
    output logic                 stats_valid,
    input  logic                 stats_ack
);

    localparam int W2 = 2 * width;

    // The tile limit must fit in the count register, and the fraction cannot
    // be wider than the score word.
    if (FRACTIONAL_BITS > W2 || MAX_TILES < 1 ||
        longint'(MAX_TILES) > (longint'(1) << W2) - 1) begin : g_param_check
        $error("block_stats_collector: MAX_TILES or FRACTIONAL_BITS out of range");
    end

    localparam logic [W2-1:0] MAX_COUNT = W2'(MAX_TILES);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_t;

    // Running statistics of one lane.
    typedef struct packed {
        logic [W2-1:0] mn;
        logic [W2-1:0] mx;
        logic [W2-1:0] sm;
        logic          sat;
    } lane_t;

    state_t        state;
    lane_t         lane0;
    lane_t         lane1;
    logic [W2-1:0] count_next;
    logic          accept;
    logic          block_end;

    // Folds one score into a lane: min/max compare plus an unsigned add that
    // clamps to all-ones. The sticky flag records any overflow.
    function automatic lane_t fold(input lane_t cur, input logic [W2-1:0] score);
        lane_t       nxt;
        logic [W2:0] total;
        total   = {1'b0, cur.sm} + {1'b0, score};
        nxt.mn  = (score < cur.mn) ? score : cur.mn;
        nxt.mx  = (score > cur.mx) ? score : cur.mx;
        nxt.sm  = total[W2] ? {W2{1'b1}} : total[W2-1:0];
        nxt.sat = cur.sat | total[W2];
        return nxt;
    endfunction

    assign count_next = noOfTiles + W2'(1);

    // Decide whether this cycle accepts a beat and whether that beat closes the block.
    always_comb begin
        // NOTE: every signal gets a default before any branch, so no path
        // leaves it unassigned and no latch is inferred.
        accept    = 1'b0;
        block_end = 1'b0;
        if (state == ACCUM) begin
            accept    = tile_valid & tile_ready;
            block_end = accept & (tile_last | (count_next == MAX_COUNT));
        end
    end

    // Control FSM and statistics registers; all outputs come straight from flops.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: every register here is reset, because each one is visible on a port.
        // A wide storage array would be left unreset instead.
        if (!rst_n) begin
            state       <= IDLE;
            tile_ready  <= 1'b0;
            stats_valid <= 1'b0;
            noOfTiles   <= '0;
            lane0       <= '0;
            lane1       <= '0;
        end else begin
            // NOTE: non-blocking assignments throughout, so every register
            // samples values from before the edge, whatever the statement order.
            case (state)
                IDLE: begin
                    // Stats of the previous block stay visible until this clear.
                    if (start) begin
                        noOfTiles  <= '0;
                        lane0      <= '{mn: {W2{1'b1}}, mx: '0, sm: '0, sat: 1'b0};
                        lane1      <= '{mn: {W2{1'b1}}, mx: '0, sm: '0, sat: 1'b0};
                        tile_ready <= 1'b1;
                        state      <= ACCUM;
                    end
                end

                ACCUM: begin
                    if (accept) begin
                        lane0     <= fold(lane0, score0);
                        lane1     <= fold(lane1, score1);
                        noOfTiles <= count_next;
                    end
                    if (block_end) begin
                        tile_ready  <= 1'b0;
                        stats_valid <= 1'b1;
                        state       <= DONE;
                    end
                end

                DONE: begin
                    if (stats_ack) begin
                        stats_valid <= 1'b0;
                        state       <= IDLE;
                    end
                end

                default: begin
                    tile_ready  <= 1'b0;
                    stats_valid <= 1'b0;
                    state       <= IDLE;
                end
            endcase
        end
    end

    assign min0    = lane0.mn;
    assign max0    = lane0.mx;
    assign sum0    = lane0.sm;
    assign min1    = lane1.mn;
    assign max1    = lane1.mx;
    assign sum1    = lane1.sm;
    assign sum_sat = {lane1.sat, lane0.sat};

endmodule

// File: tb/tb_block_stats_collector.sv
// Bench for block_stats_collector.
// Two instances share every input: one uses the default tile limit (255) and
// one uses a limit of 4. The expected statistics come from the list of scores
// offered in each block, using plain integer min/max/sum with a clamp.

module tb_block_stats_collector;

    localparam int W2          = 16;
    localparam int LIMIT_MAIN  = 255;
    localparam int LIMIT_SMALL = 4;

    typedef struct {
        int unsigned cnt;
        int unsigned mn0;
        int unsigned mx0;
        int unsigned sm0;
        int unsigned mn1;
        int unsigned mx1;
        int unsigned sm1;
        int unsigned sat;
    } stats_t;

    logic          clk        = 1'b0;
    logic          rst_n      = 1'b1;
    logic          start      = 1'b0;
    logic          tile_valid = 1'b0;
    logic          tile_last  = 1'b0;
    logic          stats_ack  = 1'b0;
    logic [W2-1:0] score0     = '0;
    logic [W2-1:0] score1     = '0;

    logic          m_ready, m_valid, s_ready, s_valid;
    logic [W2-1:0] m_count, m_min0, m_max0, m_sum0, m_min1, m_max1, m_sum1;
    logic [W2-1:0] s_count, s_min0, s_max0, s_sum0, s_min1, s_max1, s_sum1;
    logic [1:0]    m_sat, s_sat;

    int          n_checks = 0;
    int          n_errors = 0;
    int unsigned blk0[$];
    int unsigned blk1[$];
    int          m_acc, s_acc;
    bit          m_fin, s_fin;
    stats_t      zero_stats = '{default: 0};

    always #5 clk = ~clk;

    block_stats_collector dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .tile_valid(tile_valid), .tile_ready(m_ready), .tile_last(tile_last),
        .score0(score0), .score1(score1), .noOfTiles(m_count),
        .min0(m_min0), .max0(m_max0), .sum0(m_sum0),
        .min1(m_min1), .max1(m_max1), .sum1(m_sum1),
        .sum_sat(m_sat), .stats_valid(m_valid), .stats_ack(stats_ack)
    );

    block_stats_collector #(.MAX_TILES(LIMIT_SMALL)) dut_small (
        .clk(clk), .rst_n(rst_n), .start(start),
        .tile_valid(tile_valid), .tile_ready(s_ready), .tile_last(tile_last),
        .score0(score0), .score1(score1), .noOfTiles(s_count),
        .min0(s_min0), .max0(s_max0), .sum0(s_sum0),
        .min1(s_min1), .max1(s_max1), .sum1(s_sum1),
        .sum_sat(s_sat), .stats_valid(s_valid), .stats_ack(stats_ack)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Expected statistics of the first n scores of the current block.
    function automatic stats_t calc(input int n);
        stats_t      e;
        int unsigned s0 = 0;
        int unsigned s1 = 0;
        e.cnt = n;
        e.mn0 = 32'hFFFF; e.mx0 = 0;
        e.mn1 = 32'hFFFF; e.mx1 = 0;
        for (int i = 0; i < n; i++) begin
            if (blk0[i] < e.mn0) e.mn0 = blk0[i];
            if (blk0[i] > e.mx0) e.mx0 = blk0[i];
            if (blk1[i] < e.mn1) e.mn1 = blk1[i];
            if (blk1[i] > e.mx1) e.mx1 = blk1[i];
            s0 += blk0[i];
            s1 += blk1[i];
        end
        e.sat = 0;
        e.sm0 = (s0 > 32'hFFFF) ? 32'hFFFF : s0;
        e.sm1 = (s1 > 32'hFFFF) ? 32'hFFFF : s1;
        if (s0 > 32'hFFFF) e.sat |= 1;
        if (s1 > 32'hFFFF) e.sat |= 2;
        return e;
    endfunction

    task automatic check_stats(input string who, input stats_t e,
                               input logic [W2-1:0] cnt, input logic [W2-1:0] mn0,
                               input logic [W2-1:0] mx0, input logic [W2-1:0] sm0,
                               input logic [W2-1:0] mn1, input logic [W2-1:0] mx1,
                               input logic [W2-1:0] sm1, input logic [1:0] sat);
        check({who, ".noOfTiles"}, 32'(cnt), e.cnt);
        check({who, ".min0"}, 32'(mn0), e.mn0);
        check({who, ".max0"}, 32'(mx0), e.mx0);
        check({who, ".sum0"}, 32'(sm0), e.sm0);
        check({who, ".min1"}, 32'(mn1), e.mn1);
        check({who, ".max1"}, 32'(mx1), e.mx1);
        check({who, ".sum1"}, 32'(sm1), e.sm1);
        check({who, ".sum_sat"}, 32'(sat), e.sat);
    endtask

    task automatic check_main(input string tag, input stats_t e);
        check_stats({tag, "/main"}, e, m_count, m_min0, m_max0, m_sum0,
                    m_min1, m_max1, m_sum1, m_sat);
    endtask

    task automatic check_small(input string tag, input stats_t e);
        check_stats({tag, "/small"}, e, s_count, s_min0, s_max0, s_sum0,
                    s_min1, s_max1, s_sum1, s_sat);
    endtask

    task automatic check_flags(input string tag, input bit rdy, input bit vld_m, input bit vld_s);
        check({tag, "/main.tile_ready"}, 32'(m_ready), 32'(rdy));
        check({tag, "/small.tile_ready"}, 32'(s_ready), 32'(rdy));
        check({tag, "/main.stats_valid"}, 32'(m_valid), 32'(vld_m));
        check({tag, "/small.stats_valid"}, 32'(s_valid), 32'(vld_s));
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic gen(input int n, input bit big);
        blk0 = {};
        blk1 = {};
        for (int i = 0; i < n; i++) begin
            blk0.push_back(big ? $urandom_range(32'hFFFF, 32'hA000) : $urandom_range(32'h0FFF, 0));
            blk1.push_back($urandom_range(32'hFFFF, 0));
        end
    endtask

    // Runs one block from start to acknowledge. Scores come from blk0/blk1, and
    // tile_last is set on the final offered beat. Idle cycles between beats
    // carry random tile_last and score values, which must be ignored.
    task automatic run_block(input string name, input int gap_min, input int gap_max,
                             input int ack_delay);
        int n;
        bit last_now;
        n = blk0.size();
        m_acc = 0; s_acc = 0; m_fin = 0; s_fin = 0;

        start = 1'b1;
        step();
        start = 1'b0;
        check_flags({name, ":start"}, 1'b1, 1'b0, 1'b0);
        check_main({name, ":cleared"}, calc(0));
        check_small({name, ":cleared"}, calc(0));

        for (int i = 0; i < n; i++) begin
            if (i > 0) begin
                int gaps;
                gaps = $urandom_range(gap_max, gap_min);
                for (int g = 0; g < gaps; g++) begin
                    tile_valid = 1'b0;
                    tile_last  = 1'($urandom_range(1, 0));
                    score0     = W2'($urandom);
                    score1     = W2'($urandom);
                    step();
                end
            end
            last_now   = (i == n - 1);
            tile_valid = 1'b1;
            tile_last  = last_now;
            score0     = W2'(blk0[i]);
            score1     = W2'(blk1[i]);
            check({name, ":beat/main.tile_ready"}, 32'(m_ready), 32'(!m_fin));
            check({name, ":beat/small.tile_ready"}, 32'(s_ready), 32'(!s_fin));
            step();
            if (!m_fin) begin
                m_acc++;
                if (last_now || m_acc == LIMIT_MAIN) m_fin = 1'b1;
            end
            if (!s_fin) begin
                s_acc++;
                if (last_now || s_acc == LIMIT_SMALL) s_fin = 1'b1;
            end
            check({name, ":beat/main.stats_valid"}, 32'(m_valid), 32'(m_fin));
            check({name, ":beat/small.stats_valid"}, 32'(s_valid), 32'(s_fin));
        end
        tile_valid = 1'b0;
        tile_last  = 1'b0;

        for (int k = 0; k < ack_delay; k++) begin
            check_flags({name, ":hold"}, 1'b0, 1'b1, 1'b1);
            check_main({name, ":hold"}, calc(m_acc));
            check_small({name, ":hold"}, calc(s_acc));
            start      = 1'($urandom_range(1, 0));
            tile_valid = 1'($urandom_range(1, 0));
            step();
        end
        start      = 1'b0;
        tile_valid = 1'b0;
        check_flags({name, ":pre_ack"}, 1'b0, 1'b1, 1'b1);
        check_main({name, ":pre_ack"}, calc(m_acc));
        check_small({name, ":pre_ack"}, calc(s_acc));

        stats_ack = 1'b1;
        step();
        stats_ack = 1'b0;
        check_flags({name, ":ack"}, 1'b0, 1'b0, 1'b0);
        check_main({name, ":after_ack"}, calc(m_acc));
        check_small({name, ":after_ack"}, calc(s_acc));

        stats_ack = 1'b1;
        step();
        stats_ack = 1'b0;
        check_flags({name, ":idle_ack"}, 1'b0, 1'b0, 1'b0);
        check_main({name, ":idle_hold"}, calc(m_acc));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        #2 rst_n = 1'b0;
        #1;
        check_flags("reset", 1'b0, 1'b0, 1'b0);
        check_main("reset", zero_stats);
        check_small("reset", zero_stats);
        step();
        step();
        rst_n = 1'b1;
        step();
        check_flags("reset_idle", 1'b0, 1'b0, 1'b0);

        blk0 = {32'h0100, 32'h0300, 32'h0200};
        blk1 = {32'h0050, 32'h0010, 32'h0090};
        run_block("three_beats", 0, 0, 2);
        check("three_beats:sum0_const", 32'(m_sum0), 32'h0600);

        blk0 = {32'h1234};
        blk1 = {32'h00AB};
        run_block("single", 0, 0, 1);

        blk0 = {32'hFF00, 32'h0200};
        blk1 = {32'h0001, 32'h0002};
        run_block("saturate", 0, 0, 1);

        gen(3, 1'b0);
        run_block("toggle_valid", 1, 1, 5);

        gen(6, 1'b0);
        run_block("limit4", 0, 0, 2);

        gen(257, 1'b0);
        run_block("limit255", 0, 0, 1);

        // Abort a block after two beats with an asynchronous reset.
        gen(2, 1'b1);
        start = 1'b1;
        step();
        start      = 1'b0;
        tile_valid = 1'b1;
        score0     = W2'(blk0[0]);
        score1     = W2'(blk1[0]);
        step();
        score0 = W2'(blk0[1]);
        score1 = W2'(blk1[1]);
        step();
        tile_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check_flags("mid_reset", 1'b0, 1'b0, 1'b0);
        check_main("mid_reset", zero_stats);
        check_small("mid_reset", zero_stats);
        #1 rst_n = 1'b1;
        step();
        gen(3, 1'b0);
        run_block("after_reset", 0, 1, 1);

        for (int b = 0; b < 10; b++) begin
            gen($urandom_range(12, 1), 1'($urandom_range(1, 0)));
            run_block($sformatf("rand%0d", b), 0, 2, $urandom_range(3, 0));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
